ui_debounce: RTL and testbench
==============================

# ui_debounce

Input-conditioning stage that sits directly upstream of the inverter top level. It synchronises the 8 dedicated input pins into the clock domain and debounces them as one word. It presents a clean `stable_out` byte, which drives the inverter's `ui_in`, together with one-cycle change and edge strobes. Debounce is word-wide: an update commits only after the synchronised word has held one value for `DB_CYCLES` consecutive cycles.

## Interface
- `WIDTH`, default 8: input/output word width.
- `DB_CYCLES`, default 1000: consecutive stable cycles required to commit; legal range 2 to 2^`CNT_W`.
- `CNT_W`, default 10: settle counter width; must hold `DB_CYCLES-1`.

- `clk`: input, 1 bit; sole clock, rising edge.
- `rst`: input, 1 bit; synchronous, active-high reset.
- `ena`: input, 1 bit; clock enable; low freezes all state.
- `raw_in`: input, `WIDTH` bits; asynchronous pin values.
- `stable_out`: output, `WIDTH` bits; debounced word, registered.
- `changed`: output, 1 bit; one-cycle pulse on the cycle `stable_out` takes a new value.
- `rise`: output, `WIDTH` bits; per-bit pulse, bit went 0→1 in this commit.
- `fall`: output, `WIDTH` bits; per-bit pulse, bit went 1→0 in this commit.

## Operation
- Synchroniser: two flops per bit (`s1 <= raw_in`, `s2 <= s1`). Only `s2` is used downstream of the synchroniser.
- Internal registers: `cand[WIDTH]` (candidate word), `cnt[CNT_W]` (settle counter), `state` (IDLE or SETTLE).
- IDLE:
  - `s2 == stable_out`: remain in IDLE.
  - `s2 != stable_out`: `cand <= s2`, `cnt <= 0`, go to SETTLE.
- SETTLE: rules are evaluated in priority order.
  1. `s2 == stable_out` (bounced back): go to IDLE, no commit, no pulse.
  2. `s2 != cand`: `cand <= s2`, `cnt <= 0`, stay in SETTLE (restart).
  3. `cnt == DB_CYCLES-1`: commit and go to IDLE.
     - `stable_out <= cand`
     - `changed <= 1`
     - `rise <= cand & ~stable_out`
     - `fall <= ~cand & stable_out`
  4. Otherwise: `cnt <= cnt + 1`.
- `changed`, `rise` and `fall` are registered and are 0 on every cycle without a commit.
- Multiple bits changing together, or staggered within the settle window, produce a single commit of the final word.
- `ena` low:
  - All registers hold, including both synchroniser flops.
  - `changed`, `rise` and `fall` are forced to 0 on the next edge.
  - A commit due on that edge is deferred until `ena` returns high.
- `cnt` never exceeds `DB_CYCLES-1`, so no wrap-around is possible.

## Timing
- Reset values on the edge where `rst` is high:
  - `s1`, `s2`, `cand`, `cnt`, `stable_out`, `rise`, `fall`: 0.
  - `changed`: 0.
  - `state`: IDLE.
- `rst` has priority over `ena`.
- Reset mid-SETTLE discards the candidate with no pulse.
- A nonzero `raw_in` held through reset is debounced in normally after reset is released.
- Latency, with `ena` high and `raw_in` stable:
  - Edge 1 is the first edge that samples the new value into `s1`.
  - `stable_out`, `changed`, `rise` and `fall` update together on edge `DB_CYCLES+3`.
- Rejected pulses:
  - Any `raw_in` excursion shorter than `DB_CYCLES` cycles, as seen at `s2`, produces no output change.
  - A glitch of one cycle or less may be dropped by the synchroniser entirely.
- Strobes are high for exactly one cycle per commit. Back-to-back commits are separated by at least `DB_CYCLES+1` cycles.

## Test plan
All scenarios use `DB_CYCLES=4`.
- **Reset:** hold `rst`=1 for 3 cycles with `raw_in`=0xFF.
  - After release: all outputs 0.
  - `stable_out`=0xFF with `changed`=1 and `rise`=0xFF on edge 7 after release.
- **Clean change:** `stable_out`=0x00, then drive `raw_in`=0x5A and hold.
  - Edge 7: `stable_out`=0x5A, `changed`=1, `rise`=0x5A, `fall`=0x00.
  - Edge 8: `changed`=0.
- **Bounce rejection:**
  - `raw_in` toggles 0x00↔0x01 every 2 cycles for 20 cycles, then returns to 0x00: `stable_out` stays 0x00, `changed` never asserts.
  - Same toggling, then settles at 0x01: exactly one commit, 7 edges after the last toggle, with `rise`=0x01.
- **Restart on new candidate:** from 0x00, `raw_in`=0x0F for 3 cycles, then 0xF0 and hold.
  - Single commit `stable_out`=0xF0, `rise`=0xF0, `fall`=0x00.
  - Commit lands 7 edges after the 0xF0 transition.
- **Falling and mixed edges:** from `stable_out`=0xF0, drive `raw_in`=0x3C.
  - `rise`=0x0C, `fall`=0xC0, `changed`=1 for one cycle.
- **`ena` freeze and reset mid-operation:**
  - Deassert `ena` for 5 cycles in SETTLE: commit is delayed by exactly 5 cycles, with no strobes while `ena`=0.
  - Separately, assert `rst` in SETTLE: no commit, and `stable_out`=0.

Source files
------------

// File: rtl/ui_debounce.sv
// ui_debounce: two-flop synchroniser and word-wide debouncer with change and per-bit edge strobes
module ui_debounce #(
  parameter int WIDTH = 8,
  parameter int DB_CYCLES = 1000,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] stable_out,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  typedef enum logic {IDLE, SETTLE} state_t;
  state_t state;
  logic [WIDTH-1:0] s1, s2, cand;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      cand <= '0;
      cnt <= '0;
      stable_out <= '0;
      changed <= 1'b0;
      rise <= '0;
      fall <= '0;
      state <= IDLE;
    end else if (!ena) begin
      changed <= 1'b0;
      rise <= '0;
      fall <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
      changed <= 1'b0;
      rise <= '0;
      fall <= '0;
      if (state == IDLE) begin
        if (s2 != stable_out) begin
          cand <= s2;
          cnt <= '0;
          state <= SETTLE;
        end
      end else if (s2 == stable_out) begin
        state <= IDLE;
      end else if (s2 != cand) begin
        cand <= s2;
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        stable_out <= cand;
        changed <= 1'b1;
        rise <= cand & ~stable_out;
        fall <= ~cand & stable_out;
        state <= IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ui_debounce.sv
// tb_ui_debounce: scenario tasks plus randomized run against a held-value reference model
module tb_ui_debounce;
  localparam int DB = 4;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b1;
  logic [7:0] raw_in = '0;
  logic [7:0] stable_out, rise, fall;
  logic changed;
  int ncmp = 0, nerr = 0;
  logic [7:0] m_s1, m_s2, m_last, m_stable, m_rise, m_fall, x;
  logic m_ch;
  int m_run;
  ui_debounce #(.WIDTH(8), .DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .ena(ena), .raw_in(raw_in),
    .stable_out(stable_out), .changed(changed), .rise(rise), .fall(fall)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_last = '0; m_run = 0;
      m_stable = '0; m_ch = 1'b0; m_rise = '0; m_fall = '0;
    end else if (!ena) begin
      m_ch = 1'b0; m_rise = '0; m_fall = '0;
    end else begin
      x = m_s2;
      m_s2 = m_s1;
      m_s1 = raw_in;
      m_run = (x == m_last) ? m_run + 1 : 1;
      m_last = x;
      m_ch = 1'b0; m_rise = '0; m_fall = '0;
      if (x != m_stable && m_run == DB + 1) begin
        m_rise = x & ~m_stable;
        m_fall = ~x & m_stable;
        m_stable = x;
        m_ch = 1'b1;
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset(input logic [7:0] v);
    rst = 1'b1; ena = 1'b1; raw_in = v;
    cyc(); cyc();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    ena = 1'b1; rst = 1'b1; raw_in = 8'hFF;
    repeat (3) cyc();
    rst = 1'b0;
    ncmp++;
    if ({stable_out, changed, rise, fall} !== 25'd0) begin
      nerr++;
      $display("FAIL reset_state got out=%h ch=%b r=%h f=%h want all 0", stable_out, changed, rise, fall);
    end
    for (int e = 1; e <= 8; e++) begin
      cyc();
      ncmp++;
      if (stable_out !== (e >= 7 ? 8'hFF : 8'h00) || changed !== (e == 7) || rise !== (e == 7 ? 8'hFF : 8'h00) || fall !== 8'h00) begin
        nerr++;
        $display("FAIL reset_release edge=%0d got out=%h ch=%b r=%h f=%h", e, stable_out, changed, rise, fall);
      end
    end
  endtask
  task automatic test_clean();
    do_reset(8'h00);
    raw_in = 8'h5A;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      ncmp++;
      if (stable_out !== (e >= 7 ? 8'h5A : 8'h00) || changed !== (e == 7) || rise !== (e == 7 ? 8'h5A : 8'h00) || fall !== 8'h00) begin
        nerr++;
        $display("FAIL clean edge=%0d got out=%h ch=%b r=%h f=%h", e, stable_out, changed, rise, fall);
      end
      ncmp++;
      if ({stable_out, changed, rise, fall} !== {m_stable, m_ch, m_rise, m_fall}) begin
        nerr++;
        $display("FAIL clean_model edge=%0d got %h/%b/%h/%h want %h/%b/%h/%h", e, stable_out, changed, rise, fall, m_stable, m_ch, m_rise, m_fall);
      end
    end
  endtask
  task automatic test_bounce();
    int commits;
    do_reset(8'h00);
    for (int i = 0; i < 30; i++) begin
      raw_in = (i < 20 && ((i >> 1) & 1) == 0) ? 8'h01 : 8'h00;
      cyc();
      ncmp++;
      if (stable_out !== 8'h00 || changed !== 1'b0) begin
        nerr++;
        $display("FAIL bounce_reject i=%0d got out=%h ch=%b want 00/0", i, stable_out, changed);
      end
    end
    commits = 0;
    for (int i = 0; i < 20; i++) begin
      raw_in = (((i >> 1) & 1) == 0) ? 8'h01 : 8'h00;
      cyc();
      if (changed) commits++;
    end
    raw_in = 8'h01;
    for (int e = 1; e <= 10; e++) begin
      cyc();
      if (changed) commits++;
      ncmp++;
      if (changed !== (e == 7) || rise !== (e == 7 ? 8'h01 : 8'h00) || stable_out !== (e >= 7 ? 8'h01 : 8'h00)) begin
        nerr++;
        $display("FAIL bounce_settle edge=%0d got out=%h ch=%b r=%h", e, stable_out, changed, rise);
      end
    end
    ncmp++;
    if (commits !== 1) begin
      nerr++;
      $display("FAIL bounce_commits got %0d want 1", commits);
    end
  endtask
  task automatic test_restart();
    do_reset(8'h00);
    raw_in = 8'h0F;
    repeat (3) begin
      cyc();
      ncmp++;
      if (changed !== 1'b0 || stable_out !== 8'h00) begin
        nerr++;
        $display("FAIL restart_early got out=%h ch=%b want 00/0", stable_out, changed);
      end
    end
    raw_in = 8'hF0;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      ncmp++;
      if (stable_out !== (e >= 7 ? 8'hF0 : 8'h00) || changed !== (e == 7) || rise !== (e == 7 ? 8'hF0 : 8'h00) || fall !== 8'h00) begin
        nerr++;
        $display("FAIL restart edge=%0d got out=%h ch=%b r=%h f=%h", e, stable_out, changed, rise, fall);
      end
    end
  endtask
  task automatic test_mixed();
    raw_in = 8'h3C;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      ncmp++;
      if (stable_out !== (e >= 7 ? 8'h3C : 8'hF0) || changed !== (e == 7) || rise !== (e == 7 ? 8'h0C : 8'h00) || fall !== (e == 7 ? 8'hC0 : 8'h00)) begin
        nerr++;
        $display("FAIL mixed edge=%0d got out=%h ch=%b r=%h f=%h", e, stable_out, changed, rise, fall);
      end
    end
  endtask
  task automatic test_ena_rst();
    do_reset(8'h00);
    raw_in = 8'hA5;
    for (int e = 1; e <= 13; e++) begin
      ena = !(e >= 5 && e <= 9);
      cyc();
      ncmp++;
      if (stable_out !== (e >= 12 ? 8'hA5 : 8'h00) || changed !== (e == 12) || rise !== (e == 12 ? 8'hA5 : 8'h00)) begin
        nerr++;
        $display("FAIL ena_freeze edge=%0d got out=%h ch=%b r=%h", e, stable_out, changed, rise);
      end
    end
    ena = 1'b1;
    do_reset(8'h00);
    raw_in = 8'h77;
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    raw_in = 8'h00;
    for (int e = 0; e < 10; e++) begin
      ncmp++;
      if (stable_out !== 8'h00 || changed !== 1'b0) begin
        nerr++;
        $display("FAIL rst_settle e=%0d got out=%h ch=%b want 00/0", e, stable_out, changed);
      end
      cyc();
    end
  endtask
  task automatic test_random();
    int hold, commits;
    hold = 0;
    commits = 0;
    do_reset(8'h00);
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        raw_in = 8'($urandom_range(0, 15)) << ($urandom_range(0, 1) * 4);
        hold = $urandom_range(1, 10);
      end
      hold--;
      ena = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 399) == 0);
      cyc();
      if (changed) commits++;
      ncmp++;
      if ({stable_out, changed, rise, fall} !== {m_stable, m_ch, m_rise, m_fall}) begin
        nerr++;
        $display("FAIL random i=%0d got %h/%b/%h/%h want %h/%b/%h/%h", i, stable_out, changed, rise, fall, m_stable, m_ch, m_rise, m_fall);
      end
    end
    rst = 1'b0;
    ena = 1'b1;
    ncmp++;
    if (commits < 20) begin
      nerr++;
      $display("FAIL random_activity got %0d commits want >=20", commits);
    end
  endtask
  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_restart();
    test_mixed();
    test_ena_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
